line_buffer_taps: RTL and testbench

//  Parametrised multi-line buffer for the CCD edge pipeline: takes a raster pixel stream and

---
 rtl/line_buffer_taps.sv | 112 +++++++++++
 tb/tb_line_buffer_taps.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_taps.sv
// Multi-line buffer: presents TAPS vertically aligned pixels per column from a raster stream.
// Optional LINEBUF_SOF_EN adds an in_sof input that realigns column and line count to a frame start.
module line_buffer_taps #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned LINE_W = 1280,
  parameter int unsigned TAPS   = 3,
  parameter int unsigned ADDR_W = 11
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
`ifdef LINEBUF_SOF_EN
  input  logic                     in_sof,
`endif
  output logic                     out_valid,
  output logic [TAPS*DATA_W-1:0]   out_taps,
  output logic [ADDR_W-1:0]        out_col,
  output logic                     out_full,
  output logic                     line_done
);

  localparam int unsigned LcW = $clog2(TAPS);
  localparam logic [ADDR_W-1:0] LastCol = ADDR_W'(LINE_W - 1);
  localparam logic [LcW-1:0]    MaxLine = LcW'(TAPS - 1);

  logic sof_hit;
`ifdef LINEBUF_SOF_EN
  assign sof_hit = in_valid & in_sof;
`else
  assign sof_hit = 1'b0;
`endif

  logic [ADDR_W-1:0] col_q, col_d, cur_col;
  logic [LcW-1:0]    line_q, line_d, cur_line;
  logic [TAPS-1:0]   tap_en_d, tap_en_q;
  logic [DATA_W-1:0] tap0_q;
  logic [DATA_W-1:0] tap_raw [TAPS];

  // A start-of-frame pixel is treated as column 0 of a fresh line count before use.
  always_comb begin
    cur_col  = sof_hit ? '0 : col_q;
    cur_line = sof_hit ? '0 : line_q;
    col_d    = col_q;
    line_d   = line_q;
    if (in_valid) begin
      col_d  = (cur_col == LastCol) ? '0 : cur_col + 1'b1;
      line_d = cur_line;
      if ((cur_col == LastCol) && (cur_line != MaxLine)) begin
        line_d = cur_line + 1'b1;
      end
    end
    tap_en_d = '0;
    for (int k = 0; k < int'(TAPS); k++) begin
      tap_en_d[k] = (LcW'(k) <= cur_line);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q     <= '0;
      line_q    <= '0;
      out_valid <= 1'b0;
      out_col   <= '0;
      out_full  <= 1'b0;
      line_done <= 1'b0;
      tap0_q    <= '0;
      tap_en_q  <= '0;
    end else begin
      col_q     <= col_d;
      line_q    <= line_d;
      out_valid <= in_valid;
      line_done <= in_valid && (cur_col == LastCol);
      if (in_valid) begin
        out_col  <= cur_col;
        out_full <= (cur_line == MaxLine);
        tap0_q   <= in_data;
        tap_en_q <= tap_en_d;
      end
    end
  end

  assign tap_raw[0] = tap0_q;

  // RAM k-1 holds the line seen on tap k-1 and is read back as tap k one line later.
  for (genvar k = 1; k < TAPS; k++) begin : g_ram
    logic [DATA_W-1:0] mem [LINE_W];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clock) begin
      if (out_valid) begin
        mem[out_col] <= out_taps[(k-1)*DATA_W +: DATA_W];
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        rd_q <= '0;
      end else if (in_valid) begin
        rd_q <= mem[cur_col];
      end
    end

    assign tap_raw[k] = rd_q;
  end

  // Taps deeper than the lines received so far read 0, hiding stale RAM contents.
  for (genvar k = 0; k < TAPS; k++) begin : g_out
    assign out_taps[k*DATA_W +: DATA_W] = tap_en_q[k] ? tap_raw[k] : '0;
  end

endmodule

// File: tb/tb_line_buffer_taps.sv
// Directed bench for line_buffer_taps: LINE_W=4 and LINE_W=5 instances, TAPS=3, DATA_W=10.
module tb_line_buffer_taps;
  localparam int DW = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iv0 = 1'b0, iv1 = 1'b0, sof0 = 1'b0, sof1 = 1'b0;
  logic [DW-1:0] id0 = '0, id1 = '0;

  logic ov0, full0, done0, ov1, full1, done1;
  logic [3*DW-1:0] taps0, taps1;
  logic [1:0] col0;
  logic [2:0] col1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  line_buffer_taps #(.DATA_W(10), .LINE_W(4), .TAPS(3), .ADDR_W(2)) u0 (
    .clock(clock), .reset(reset), .in_valid(iv0), .in_data(id0),
`ifdef LINEBUF_SOF_EN
    .in_sof(sof0),
`endif
    .out_valid(ov0), .out_taps(taps0), .out_col(col0), .out_full(full0), .line_done(done0)
  );

  line_buffer_taps #(.DATA_W(10), .LINE_W(5), .TAPS(3), .ADDR_W(3)) u1 (
    .clock(clock), .reset(reset), .in_valid(iv1), .in_data(id1),
`ifdef LINEBUF_SOF_EN
    .in_sof(sof1),
`endif
    .out_valid(ov1), .out_taps(taps1), .out_col(col1), .out_full(full1), .line_done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Expected tap k for pixel (line l, col c) of a stream valued base+16*line+col.
  function automatic logic [31:0] mtap(input int l, input int c, input int k, input int base);
    return (l >= k) ? 32'(base + 16 * (l - k) + c) : 32'd0;
  endfunction

  task automatic chk0(input int l, input int c, input int base);
    string p;
    p = $sformatf("u0 L%0dC%0d", l, c);
    chk({p, " valid"}, 32'(ov0), 32'd1);
    chk({p, " col"}, 32'(col0), 32'(c));
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s tap%0d", p, k), 32'(taps0[k*DW +: DW]), mtap(l, c, k, base));
    chk({p, " full"}, 32'(full0), 32'(l >= 2));
    chk({p, " done"}, 32'(done0), 32'(c == 3));
  endtask

  task automatic chk1(input int l, input int c);
    string p;
    p = $sformatf("u1 L%0dC%0d", l, c);
    chk({p, " valid"}, 32'(ov1), 32'd1);
    chk({p, " col"}, 32'(col1), 32'(c));
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s tap%0d", p, k), 32'(taps1[k*DW +: DW]), mtap(l, c, k, 0));
    chk({p, " full"}, 32'(full1), 32'(l >= 2));
    chk({p, " done"}, 32'(done1), 32'(c == 4));
  endtask

  task automatic step0(input logic v, input int d, input logic s);
    @(negedge clock);
    iv0 = v; id0 = DW'(d); sof0 = s;
    @(posedge clock);
    #1;
  endtask

  task automatic step1(input logic v, input int d);
    @(negedge clock);
    iv1 = v; id1 = DW'(d);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; iv0 = 1'b0; iv1 = 1'b0; sof0 = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst valid", 32'(ov0), 32'd0);
    chk("rst taps", 32'(taps0), 32'd0);
    chk("rst col", 32'(col0), 32'd0);
    chk("rst full", 32'(full0), 32'd0);
    chk("rst done", 32'(done0), 32'd0);
    chk("rst u1 taps", 32'(taps1), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Three contiguous lines
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 4; c++) begin
        step0(1'b1, 16 * l + c, 1'b0);
        chk0(l, c, 0);
      end

    // Same stream with alternating gaps; outputs hold during gaps
    do_reset();
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 4; c++) begin
        step0(1'b1, 16 * l + c, 1'b0);
        chk0(l, c, 0);
        step0(1'b0, 0, 1'b0);
        chk("gap valid", 32'(ov0), 32'd0);
        chk("gap done", 32'(done0), 32'd0);
        chk("gap col hold", 32'(col0), 32'(c));
        chk("gap tap0 hold", 32'(taps0[DW-1:0]), 32'(16 * l + c));
      end

    // Six lines: wrap, line_done each line, line count saturates
    do_reset();
    for (int l = 0; l < 6; l++)
      for (int c = 0; c < 4; c++) begin
        step0(1'b1, 16 * l + c, 1'b0);
        chk0(l, c, 0);
      end

    // Reset mid-line at line 1 col 2
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step0(1'b1, 16 * (i / 4) + (i % 4), 1'b0);
      chk0(i / 4, i % 4, 0);
    end
    @(negedge clock);
    reset = 1'b1; iv0 = 1'b1; id0 = 10'd18;
    @(posedge clock);
    #1;
    chk("midrst valid", 32'(ov0), 32'd0);
    chk("midrst taps", 32'(taps0), 32'd0);
    chk("midrst col", 32'(col0), 32'd0);
    chk("midrst full", 32'(full0), 32'd0);
    chk("midrst done", 32'(done0), 32'd0);
    @(negedge clock);
    reset = 1'b0; iv0 = 1'b1; id0 = 10'd99;
    @(posedge clock);
    #1;
    chk0(0, 0, 99);
    step0(1'b1, 100, 1'b0);
    chk0(0, 1, 99);

`ifdef LINEBUF_SOF_EN
    // Start of frame at line 3 col 2 realigns to col 0 / line 0
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step0(1'b1, 16 * (i / 4) + (i % 4), 1'b0);
      chk0(i / 4, i % 4, 0);
    end
    step0(1'b1, 200, 1'b1);
    chk0(0, 0, 200);
    for (int i = 1; i < 12; i++) begin
      step0(1'b1, 200 + 16 * (i / 4) + (i % 4), 1'b0);
      chk0(i / 4, i % 4, 200);
    end
`endif

    // Non power-of-two line length
    do_reset();
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 5; c++) begin
        step1(1'b1, 16 * l + c);
        chk1(l, c);
      end
    step1(1'b0, 0);
    chk("u1 idle valid", 32'(ov1), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
